port_bus_hub: RTL and testbench

Parametrised successor to the hand-wired address decoder, LED register and RAM/IN_PORT mux in the core top level. It sits between the tramelblaze port bus and the peripherals. It provides:
- a bank of NUM_OUT output registers;
- per-port read and write strobes;
- a registered input mux with uniform 1-cycle read latency;
- a memory window onto a synchronous RAM;
- an NUM_IRQ-channel prioritised interrupt aggregator with mask and acknowledge.

---
 rtl/port_bus_hub.sv | 223 ++++++++++++++++++++++
 tb/tb_port_bus_hub.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/port_bus_hub.sv
// port_bus_hub
// Sits between the tramelblaze port bus and the peripherals. Decodes PORT_ID
// into three spaces (RAM window, hub control space, peripheral space) and
// provides:
//   - NUM_OUT output registers with one-cycle write pulses,
//   - NUM_IN read pulses and a registered read mux with 1-cycle latency,
//   - a window onto an external synchronous RAM,
//   - an NUM_IRQ-channel prioritised interrupt aggregator with mask,
//     write-1-to-clear pending and acknowledge.
//
// Ports:
//   clk, reset        system clock; asynchronous active-low reset
//   PORT_ID/OUT_PORT  processor address / write data
//   READ_STROBE       processor read strobe (one cycle)
//   WRITE_STROBE      processor write strobe (one cycle)
//   INT_ACK           processor interrupt acknowledge (one cycle)
//   IN_PORT           read data to processor, valid the edge after READ_STROBE
//   INTERRUPT         registered level interrupt to processor
//   in_data/out_data  packed peripheral ports, port k at [k*DATA_W +: DATA_W]
//   writes/reads      per-port one-cycle strobes
//   irq_req           interrupt request levels (synchronous to clk)
//   ram_addr/ram_din/ram_we/ram_rdata  synchronous RAM interface
//
// Address map: PORT_ID[ADDR_W-1]=1 selects RAM; otherwise PORT_ID[ADDR_W-2]=1
// selects control space (0 mask, 1 pending W1C, 2 id, 3 reserved), and 0
// selects peripheral space indexed by the low PORT_ID bits.

module port_bus_hub #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int NUM_OUT = 8,
  parameter int NUM_IN  = 8,
  parameter int NUM_IRQ = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_W-1:0]         PORT_ID,
  input  logic [DATA_W-1:0]         OUT_PORT,
  input  logic                      READ_STROBE,
  input  logic                      WRITE_STROBE,
  input  logic                      INT_ACK,
  output logic [DATA_W-1:0]         IN_PORT,
  output logic                      INTERRUPT,
  input  logic [NUM_IN*DATA_W-1:0]  in_data,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  output logic [NUM_OUT-1:0]        writes,
  output logic [NUM_IN-1:0]         reads,
  input  logic [NUM_IRQ-1:0]        irq_req,
  output logic [ADDR_W-2:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_din,
  output logic                      ram_we,
  input  logic [DATA_W-1:0]         ram_rdata
);

  localparam int OUT_IW = $clog2(NUM_OUT);
  localparam int IN_IW  = $clog2(NUM_IN);
  // The id register always carries a 4-bit index so that software sees the
  // valid flag at the same bit position for any channel count.
  localparam int IDX_W  = 4;

  typedef enum logic [1:0] {
    SRC_PER  = 2'd0,
    SRC_CTRL = 2'd1,
    SRC_RAM  = 2'd2
  } rd_src_t;

  // Strobes are suppressed while reset is held so nothing downstream
  // (including the external RAM) sees activity during reset.
  logic rd_en;
  logic wr_en;
  assign rd_en = READ_STROBE & reset;
  assign wr_en = WRITE_STROBE & reset;

  logic sel_ram;
  logic sel_ctrl;
  logic sel_per;
  assign sel_ram  = PORT_ID[ADDR_W-1];
  assign sel_ctrl = ~PORT_ID[ADDR_W-1] & PORT_ID[ADDR_W-2];
  assign sel_per  = ~PORT_ID[ADDR_W-1] & ~PORT_ID[ADDR_W-2];

  logic [1:0] ctrl_addr;
  assign ctrl_addr = PORT_ID[1:0];

  assign ram_addr = PORT_ID[ADDR_W-2:0];
  assign ram_din  = OUT_PORT;
  assign ram_we   = wr_en & sel_ram;

  // ---------------------------------------------------------------------------
  // Output register bank and write strobes
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUT; gi++) begin : g_out
      logic [DATA_W-1:0] port_reg;

      assign writes[gi] = wr_en & sel_per & (PORT_ID[OUT_IW-1:0] == OUT_IW'(gi));

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          port_reg <= '0;
        end else if (writes[gi]) begin
          port_reg <= OUT_PORT;
        end
      end

      assign out_data[gi*DATA_W +: DATA_W] = port_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Input ports and read strobes
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] in_arr [NUM_IN];

  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_in
      assign in_arr[gi] = in_data[gi*DATA_W +: DATA_W];
      assign reads[gi]  = rd_en & sel_per & (PORT_ID[IN_IW-1:0] == IN_IW'(gi));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Interrupt aggregator
  // ---------------------------------------------------------------------------
  logic [NUM_IRQ-1:0] mask_reg;
  logic [NUM_IRQ-1:0] pending_reg;
  logic [NUM_IRQ-1:0] pending_next;
  logic [NUM_IRQ-1:0] irq_q_reg;
  logic               armed_reg;
  logic               int_reg;

  logic [NUM_IRQ-1:0] active;
  logic [NUM_IRQ-1:0] lowest_vec;
  logic [IDX_W-1:0]   id_idx;
  logic               id_valid;
  logic [NUM_IRQ-1:0] rise_vec;
  logic [NUM_IRQ-1:0] w1c_vec;
  logic [NUM_IRQ-1:0] ack_vec;

  assign active   = pending_reg & mask_reg;
  assign id_valid = |active;

  // Lowest set bit of pending&mask: scanning downwards lets the lowest index
  // overwrite any higher one.
  always_comb begin
    id_idx     = '0;
    lowest_vec = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) begin
        id_idx        = IDX_W'(i);
        lowest_vec    = '0;
        lowest_vec[i] = 1'b1;
      end
    end
  end

  // armed_reg stays low for the first edge after reset, so a request that was
  // already high when reset released is captured as a level, not an edge.
  assign rise_vec = armed_reg ? (irq_req & ~irq_q_reg) : '0;
  assign w1c_vec  = (wr_en && sel_ctrl && ctrl_addr == 2'd1) ? OUT_PORT[NUM_IRQ-1:0] : '0;
  assign ack_vec  = (INT_ACK & reset) ? lowest_vec : '0;

  // Clears are applied first so that a new edge on the same bit wins.
  assign pending_next = (pending_reg & ~(w1c_vec | ack_vec)) | rise_vec;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_reg    <= '0;
      pending_reg <= '0;
      irq_q_reg   <= '0;
      armed_reg   <= 1'b0;
      int_reg     <= 1'b0;
    end else begin
      if (wr_en && sel_ctrl && ctrl_addr == 2'd0) begin
        mask_reg <= OUT_PORT[NUM_IRQ-1:0];
      end
      pending_reg <= pending_next;
      irq_q_reg   <= irq_req;
      armed_reg   <= 1'b1;
      int_reg     <= id_valid;
    end
  end

  assign INTERRUPT = int_reg;

  // ---------------------------------------------------------------------------
  // Read path: source and data captured on READ_STROBE, RAM data passed
  // through because the RAM itself supplies the one cycle of latency.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] ctrl_rdata;
  logic [DATA_W-1:0] rd_data_reg;
  rd_src_t           rd_src_reg;

  always_comb begin
    ctrl_rdata = '0;
    case (ctrl_addr)
      2'd0:    ctrl_rdata = DATA_W'(mask_reg);
      2'd1:    ctrl_rdata = DATA_W'(pending_reg);
      2'd2:    ctrl_rdata = DATA_W'({id_valid, id_idx});
      default: ctrl_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_src_reg  <= SRC_PER;
      rd_data_reg <= '0;
    end else if (rd_en) begin
      if (sel_ram) begin
        rd_src_reg <= SRC_RAM;
      end else if (sel_ctrl) begin
        rd_src_reg  <= SRC_CTRL;
        rd_data_reg <= ctrl_rdata;
      end else begin
        rd_src_reg  <= SRC_PER;
        rd_data_reg <= in_arr[PORT_ID[IN_IW-1:0]];
      end
    end
  end

  assign IN_PORT = (rd_src_reg == SRC_RAM) ? ram_rdata : rd_data_reg;

endmodule

// File: tb/tb_port_bus_hub.sv
// Self-checking bench for port_bus_hub: directed scenarios with literal
// expectations followed by randomized traffic checked every cycle against a
// behavioural model of the address map, port bank, read path and interrupts.

module tb_port_bus_hub;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 16;
  localparam int NUM_OUT = 8;
  localparam int NUM_IN  = 8;
  localparam int NUM_IRQ = 4;

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic [ADDR_W-1:0]         port_id = '0;
  logic [DATA_W-1:0]         out_port = '0;
  logic                      read_strobe = 1'b0;
  logic                      write_strobe = 1'b0;
  logic                      int_ack = 1'b0;
  logic [DATA_W-1:0]         in_port;
  logic                      interrupt;
  logic [NUM_IN*DATA_W-1:0]  in_data = '0;
  logic [NUM_OUT*DATA_W-1:0] out_data;
  logic [NUM_OUT-1:0]        writes;
  logic [NUM_IN-1:0]         reads;
  logic [NUM_IRQ-1:0]        irq_req = '0;
  logic [ADDR_W-2:0]         ram_addr;
  logic [DATA_W-1:0]         ram_din;
  logic                      ram_we;
  logic [DATA_W-1:0]         ram_rdata = '0;

  always #5 clk = ~clk;

  port_bus_hub #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_OUT(NUM_OUT),
    .NUM_IN(NUM_IN), .NUM_IRQ(NUM_IRQ)
  ) dut (
    .clk(clk), .reset(reset), .PORT_ID(port_id), .OUT_PORT(out_port),
    .READ_STROBE(read_strobe), .WRITE_STROBE(write_strobe), .INT_ACK(int_ack),
    .IN_PORT(in_port), .INTERRUPT(interrupt), .in_data(in_data),
    .out_data(out_data), .writes(writes), .reads(reads), .irq_req(irq_req),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  // External synchronous RAM driven by the hub's RAM interface.
  logic [DATA_W-1:0] ram_mem [0:32767];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    ram_rdata <= ram_mem[ram_addr];
  end

  // Behavioural model state
  logic [DATA_W-1:0]  m_out [NUM_OUT];
  logic [NUM_IRQ-1:0] m_mask, m_pend, m_prev;
  logic               m_armed, m_int, m_src_ram;
  logic [DATA_W-1:0]  m_held, m_rdata;
  logic [DATA_W-1:0]  m_mem [0:32767];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] model_out_data();
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < NUM_OUT; i++) v[i*DATA_W +: DATA_W] = m_out[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_OUT; i++) m_out[i] = '0;
    m_mask = '0; m_pend = '0; m_prev = '0;
    m_armed = 1'b0; m_int = 1'b0; m_src_ram = 1'b0; m_held = '0;
  endtask

  // One active clock edge seen from the rules of the address map.
  task automatic model_edge();
    logic [NUM_IRQ-1:0] act, clr, rise;
    logic [DATA_W-1:0]  id;
    int lo;
    act = m_pend & m_mask;
    lo = -1;
    for (int i = 0; i < NUM_IRQ; i++) if (act[i] && lo < 0) lo = i;
    id = (lo < 0) ? 16'h0000 : (16'h0010 | 16'(lo));
    if (read_strobe) begin
      if (port_id[15]) m_src_ram = 1'b1;
      else begin
        m_src_ram = 1'b0;
        if (port_id[14]) begin
          case (port_id[1:0])
            2'd0:    m_held = {12'd0, m_mask};
            2'd1:    m_held = {12'd0, m_pend};
            2'd2:    m_held = id;
            default: m_held = 16'h0000;
          endcase
        end else begin
          m_held = in_data[port_id[2:0]*16 +: 16];
        end
      end
    end
    clr = '0;
    if (int_ack && lo >= 0) clr[lo] = 1'b1;
    if (write_strobe && !port_id[15] && port_id[14] && port_id[1:0] == 2'd1) clr = clr | out_port[3:0];
    rise = m_armed ? (irq_req & ~m_prev) : 4'h0;
    m_int = |act;
    if (write_strobe && !port_id[15] && port_id[14] && port_id[1:0] == 2'd0) m_mask = out_port[3:0];
    m_pend = (m_pend & ~clr) | rise;
    if (write_strobe && !port_id[15] && !port_id[14]) m_out[port_id[2:0]] = out_port;
    m_prev = irq_req;
    m_armed = 1'b1;
  endtask

  task automatic check_comb();
    logic [7:0] ew, er;
    logic       live;
    live = reset;
    ew = (live && write_strobe && port_id[15:14] == 2'b00) ? (8'd1 << port_id[2:0]) : 8'd0;
    er = (live && read_strobe  && port_id[15:14] == 2'b00) ? (8'd1 << port_id[2:0]) : 8'd0;
    chk("writes", writes, ew);
    chk("reads", reads, er);
    chk("ram_we", ram_we, live && write_strobe && port_id[15]);
    chk("ram_addr", ram_addr, port_id[14:0]);
    chk("ram_din", ram_din, out_port);
  endtask

  task automatic check_reg();
    chk("out_data", out_data, model_out_data());
    chk("IN_PORT", in_port, m_src_ram ? m_rdata : m_held);
    chk("INTERRUPT", interrupt, m_int);
  endtask

  // Called away from the edge: check decode, take the edge, check state.
  task automatic step();
    #1;
    check_comb();
    @(posedge clk);
    m_rdata = m_mem[port_id[14:0]];
    if (reset && write_strobe && port_id[15]) m_mem[port_id[14:0]] = out_port;
    if (reset) model_edge();
    else model_reset();
    #1;
    check_reg();
    @(negedge clk);
  endtask

  task automatic idle();
    read_strobe = 1'b0; write_strobe = 1'b0; int_ack = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    port_id = a; out_port = d; write_strobe = 1'b1; step(); write_strobe = 1'b0;
    $display("[TB] write %04h <- %04h", a, d);
  endtask

  task automatic do_read(input logic [15:0] a);
    port_id = a; read_strobe = 1'b1; step(); read_strobe = 1'b0;
    $display("[TB] read %04h -> %04h", a, in_port);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) begin ram_mem[i] = '0; m_mem[i] = '0; end
    model_reset();
    m_rdata = '0;
    #2 reset = 1'b0;
    @(negedge clk);
    step();
    step();
    reset = 1'b1;
    chk("rst out_data", out_data, 128'd0);
    chk("rst IN_PORT", in_port, 16'h0000);
    chk("rst INTERRUPT", interrupt, 1'b0);
    step();

    // Output bank writes
    port_id = 16'h0003; out_port = 16'h00A5; write_strobe = 1'b1;
    #1 chk("writes port3", writes, 8'h08);
    step(); write_strobe = 1'b0;
    #1 chk("writes idle", writes, 8'h00);
    chk("out3 A5", out_data, {64'd0, 16'h00A5, 48'd0});
    do_write(16'h0003, 16'h1234);
    chk("out3 1234", out_data, {64'd0, 16'h1234, 48'd0});

    // RAM window
    do_write(16'h8010, 16'hBEEF);
    #1 chk("ram_we idle", ram_we, 1'b0);
    do_read(16'h8010);
    chk("ram read", in_port, 16'hBEEF);

    // Peripheral read holds after source changes
    in_data = '0; in_data[5*16 +: 16] = 16'h5A5A;
    port_id = 16'h0005; read_strobe = 1'b1;
    #1 chk("reads port5", reads, 8'h20);
    step(); read_strobe = 1'b0;
    chk("per read", in_port, 16'h5A5A);
    in_data = '0;
    step();
    chk("per hold", in_port, 16'h5A5A);

    // Interrupt priority and acknowledge
    do_write(16'h4000, 16'h0003);
    irq_req = 4'b0011; step();
    step();
    chk("int up", interrupt, 1'b1);
    do_read(16'h4002);
    chk("id 0x10", in_port, 16'h0010);
    int_ack = 1'b1; step(); int_ack = 1'b0;
    do_read(16'h4002);
    chk("id 0x11", in_port, 16'h0011);
    int_ack = 1'b1; step(); int_ack = 1'b0;
    chk("int before drop", interrupt, 1'b1);
    step();
    chk("int dropped", interrupt, 1'b0);
    irq_req = 4'b0000; step();

    // Masked pending, unmask, set-wins-over-W1C
    do_write(16'h4000, 16'h0000);
    irq_req = 4'b0100; step();
    step();
    chk("masked int", interrupt, 1'b0);
    do_read(16'h4001);
    chk("pending 4", in_port, 16'h0004);
    do_write(16'h4000, 16'h0004);
    step();
    chk("unmask int", interrupt, 1'b1);
    irq_req = 4'b0000; step();
    irq_req = 4'b0100; do_write(16'h4001, 16'h0004);
    do_read(16'h4001);
    chk("set wins", in_port, 16'h0004);

    // Reset mid-run
    #2 reset = 1'b0; model_reset();
    #1;
    chk("mid rst out_data", out_data, 128'd0);
    chk("mid rst IN_PORT", in_port, 16'h0000);
    chk("mid rst INTERRUPT", interrupt, 1'b0);
    port_id = 16'h0002; out_port = 16'hFFFF; write_strobe = 1'b1; read_strobe = 1'b1;
    irq_req = 4'b0001;
    step(); step();
    idle();
    chk("rst strobes out", out_data, 128'd0);
    reset = 1'b1;
    step(); step();
    do_read(16'h4001);
    chk("no edge after rst", in_port, 16'h0000);
    $display("[TB] directed phase done");

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 2))
        0: port_id = 16'($urandom_range(0, 16'h3FFF));
        1: port_id = 16'h4000 | 16'($urandom_range(0, 16'h3FFF));
        default: port_id = 16'h8000 | (16'($urandom_range(0, 1)) << 14) | 16'($urandom_range(0, 15));
      endcase
      out_port     = 16'($urandom);
      read_strobe  = ($urandom_range(0, 9) < 4);
      write_strobe = ($urandom_range(0, 9) < 4);
      int_ack      = ($urandom_range(0, 9) < 2);
      for (int b = 0; b < NUM_IRQ; b++) if ($urandom_range(0, 9) == 0) irq_req[b] = ~irq_req[b];
      in_data = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
